// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, WAIT_CYCLES wait states, valid/ready on both sides.
// Optional access-error checking is enabled by defining DMEM_RSP_ERR_EN.
module dmem_responder #(
  parameter int DW             = 32,
  parameter int MEM_SIZE_IN_KB = 1,
  parameter int NO_OF_REGS     = MEM_SIZE_IN_KB*1024/4,
  parameter int WAIT_CYCLES    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [DW-1:0]   req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  input  logic [DW/8-1:0] req_be_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            rsp_err_o
);
  localparam int AW = $clog2(NO_OF_REGS);
  localparam int BW = DW/8;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t          state, state_next;
  logic [3:0]      cnt;
  logic            we_r;
  logic [AW-1:0]   idx_r;
  logic [DW-1:0]   wdata_r;
  logic [BW-1:0]   be_r;
  logic            err_r;
  logic [DW-1:0]   mem [NO_OF_REGS];

  logic            req_err;
  logic            accept;
  logic            enter_resp;
  logic            cur_we;
  logic [AW-1:0]   cur_idx;
  logic [DW-1:0]   cur_wdata;
  logic [BW-1:0]   cur_be;
  logic            cur_err;

`ifdef DMEM_RSP_ERR_EN
  localparam logic [DW-3:0] NREGS = (DW-2)'(NO_OF_REGS);
  assign req_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i[DW-1:2] >= NREGS);
`else
  logic unused_addr;
  assign unused_addr = ^{req_addr_i[DW-1:AW+2], req_addr_i[1:0]};
  assign req_err     = 1'b0;
`endif

  assign accept      = (state == IDLE) && req_valid_i;
  assign enter_resp  = (state_next == RESP) && (state != RESP);
  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);

  // With zero wait states the storage access happens on the accept edge, so use the live request.
  always_comb begin
    if (state == IDLE) begin
      cur_we    = req_we_i;
      cur_idx   = req_addr_i[AW+1:2];
      cur_wdata = req_wdata_i;
      cur_be    = req_be_i;
      cur_err   = req_err;
    end else begin
      cur_we    = we_r;
      cur_idx   = idx_r;
      cur_wdata = wdata_r;
      cur_be    = be_r;
      cur_err   = err_r;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid_i) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
        else             state_next = IDLE;
      end
      WAIT: begin
        if (cnt == 4'd0) state_next = RESP;
        else             state_next = WAIT;
      end
      RESP: begin
        if (rsp_ready_i) state_next = IDLE;
        else             state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      we_r        <= 1'b0;
      idx_r       <= '0;
      wdata_r     <= '0;
      be_r        <= '0;
      err_r       <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_r    <= req_we_i;
        idx_r   <= req_addr_i[AW+1:2];
        wdata_r <= req_wdata_i;
        be_r    <= req_be_i;
        err_r   <= req_err;
        cnt     <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_rdata_o <= (cur_we || cur_err) ? '0 : mem[cur_idx];
        rsp_err_o   <= cur_err;
      end
    end
  end

  // Storage is deliberately not reset; stores commit only on the edge entering RESP.
  always_ff @(posedge clk_i) begin
    if (enter_resp && cur_we && !cur_err) begin
      for (int b = 0; b < BW; b++) begin
        if (cur_be[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end
endmodule
